// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div: multi-cycle 32-bit signed/unsigned integer divider.
//
// Radix-2 restoring division, one quotient bit per clock. The execute stage
// holds start_i high and stalls until ready_o is returned, then writes the
// 64-bit result into HI/LO.
//
// Ports:
//   clk          in   1   clock, all state updates on the rising edge
//   rst          in   1   synchronous active-high reset
//   signed_div_i in   1   1 = signed divide, 0 = unsigned (sampled at start)
//   opdata1_i    in  32   dividend (sampled at start)
//   opdata2_i    in  32   divisor  (sampled at start)
//   start_i      in   1   divide request, held until ready_o is seen
//   annul_i      in   1   cancels an operation in progress
//   result_o     out 64   {remainder, quotient}, registered
//   ready_o      out  1   result_o valid, registered
// ---------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } divState_t;

    // Registered state
    divState_t   r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_negQ;
    logic        r_negR;

    // Next-state values produced by the combinational process
    divState_t   w_stateNext;
    logic [5:0]  w_cntNext;
    logic [64:0] w_workNext;
    logic [31:0] w_divisorNext;
    logic        w_negQNext;
    logic        w_negRNext;
    logic [63:0] w_resultNext;
    logic        w_readyNext;

    // Datapath helpers
    logic [32:0] w_diff;
    logic [31:0] w_op1Abs;
    logic [31:0] w_op2Abs;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Operand magnitudes: a negative operand is only negated for a signed
    // divide. The trial subtraction is done one bit wider so its top bit
    // tells us whether the partial remainder was smaller than the divisor.
    // The final quotient/remainder take their sign back from flags latched
    // at acceptance, so operand changes after start do not matter.
    always_comb begin
        w_op1Abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        w_op2Abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        w_diff   = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
        w_quot   = r_negQ ? (~r_work[31:0]  + 32'd1) : r_work[31:0];
        w_rem    = r_negR ? (~r_work[64:33] + 32'd1) : r_work[64:33];
    end

    // Next-state and next-output logic. Everything defaults to holding its
    // current value; each state only overrides what it changes.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_workNext    = r_work;
        w_divisorNext = r_divisor;
        w_negQNext    = r_negQ;
        w_negRNext    = r_negR;
        w_resultNext  = result_o;
        w_readyNext   = ready_o;

        case (r_state)
            DivFree: begin
                w_resultNext = 64'd0;
                w_readyNext  = 1'b0;
                if (start_i && !annul_i) begin
                    w_negQNext = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    w_negRNext = signed_div_i & opdata1_i[31];
                    if (opdata2_i == 32'd0) begin
                        w_stateNext = DivByZero;
                    end else begin
                        w_divisorNext = w_op2Abs;
                        w_workNext    = {32'd0, w_op1Abs, 1'b0};
                        w_cntNext     = 6'd0;
                        w_stateNext   = DivOn;
                    end
                end
            end

            // Divide by zero produces an all-zero result after one extra cycle.
            DivByZero: begin
                w_workNext   = 65'd0;
                w_resultNext = 64'd0;
                w_readyNext  = 1'b1;
                w_stateNext  = DivEnd;
            end

            // Annul beats the iteration step. Thirty-two restoring steps
            // shift the quotient in at the bottom while the remainder
            // accumulates in the upper half; the 33rd cycle applies signs.
            DivOn: begin
                if (annul_i) begin
                    w_stateNext  = DivFree;
                    w_resultNext = 64'd0;
                    w_readyNext  = 1'b0;
                end else if (r_cnt != 6'd32) begin
                    if (w_diff[32]) begin
                        w_workNext = {r_work[63:0], 1'b0};
                    end else begin
                        w_workNext = {w_diff[31:0], r_work[31:0], 1'b1};
                    end
                    w_cntNext = r_cnt + 6'd1;
                end else begin
                    w_resultNext = {w_rem, w_quot};
                    w_readyNext  = 1'b1;
                    w_cntNext    = 6'd0;
                    w_stateNext  = DivEnd;
                end
            end

            // Hold the result until the requester drops start; annul is
            // deliberately not looked at here.
            DivEnd: begin
                if (!start_i) begin
                    w_stateNext  = DivFree;
                    w_resultNext = 64'd0;
                    w_readyNext  = 1'b0;
                end
            end

            default: begin
                w_stateNext  = DivFree;
                w_resultNext = 64'd0;
                w_readyNext  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DivFree;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_work    <= w_workNext;
            r_divisor <= w_divisorNext;
            r_negQ    <= w_negQNext;
            r_negR    <= w_negRNext;
            result_o  <= w_resultNext;
            ready_o   <= w_readyNext;
        end
    end

endmodule

// File: tb/tb_div.sv
// ---------------------------------------------------------------------------
// tb_div: scoreboard testbench for the div divider.
//
// Stimulus pushes the expected {remainder, quotient} and latency for each
// divide that should complete; a monitor pops and compares on every rising
// ready_o. Expected values come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          stamp;
    } expItem_t;

    expItem_t expQ[$];
    int       cyc = 0;
    int       checks = 0;
    int       passes = 0;
    logic     prevReady = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference divider: integer division truncating toward zero, remainder
    // taking the dividend's sign, result zero for a zero divisor.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding divide.
    always @(negedge clk) begin
        if (ready_o === 1'b1 && prevReady !== 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedReady: ready_o=1 result=0x%016h, expected no result", result_o);
            end else begin
                expItem_t e;
                e = expQ.pop_front();
                checkVal("result", result_o, e.res);
                checkVal("latency", 64'(cyc - e.stamp), 64'(e.lat));
            end
        end
        prevReady <= ready_o;
    end

    // One divide. dropAt >= 1 drops start that many cycles after acceptance;
    // scramble changes the operand inputs right after acceptance.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input int dropAt, input bit scramble);
        expItem_t e;
        logic [63:0] exp;
        int n;
        exp = refDiv(sgn, a, b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res   = exp;
        e.lat   = (b == 32'd0) ? 2 : 34;
        e.stamp = cyc;
        expQ.push_back(e);
        @(negedge clk);
        if (scramble) begin
            signed_div_i = ~sgn;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
        end
        n = 1;
        while (ready_o !== 1'b1 && n < 60) begin
            if (n == dropAt) start_i = 1'b0;
            @(negedge clk);
            n++;
        end
        if (ready_o !== 1'b1) begin
            checks++;
            $display("[TB] FAIL readyTimeout: ready_o=%b after %0d cycles, expected 1", ready_o, n);
            start_i = 1'b0;
            void'(expQ.pop_front());
            repeat (2) @(negedge clk);
            return;
        end
        if (start_i) begin
            @(negedge clk);
            checkVal("holdReady", 64'(ready_o), 64'd1);
            checkVal("holdResult", result_o, exp);
            start_i = 1'b0;
        end
        @(negedge clk);
        checkVal("clearReady", 64'(ready_o), 64'd0);
        checkVal("clearResult", result_o, 64'd0);
    endtask

    // Start a 100/7, then abort it after iters cycles with annul or reset,
    // and confirm no result ever appears.
    task automatic applyAbort(input bit useReset, input int iters);
        bit sawReady;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (iters) @(negedge clk);
        start_i = 1'b0;
        if (useReset) rst = 1'b1;
        else annul_i = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        annul_i = 1'b0;
        checkVal(useReset ? "resetReady" : "annulReady", 64'(ready_o), 64'd0);
        checkVal(useReset ? "resetResult" : "annulResult", result_o, 64'd0);
        sawReady = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) sawReady = 1'b1;
        end
        checkVal("noReadyAfterAbort", 64'(sawReady), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("resetReady", 64'(ready_o), 64'd0);
        checkVal("resetResult", result_o, 64'd0);
        rst = 1'b0;

        // Directed cases
        applyStimulus(1'b0, 32'd100, 32'd7, -1, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, -1, 1'b0);
        applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
        applyStimulus(1'b0, 32'd12345, 32'd0, -1, 1'b0);
        applyStimulus(1'b1, 32'hFFFF0000, 32'd0, -1, 1'b0);
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, -1, 1'b0);
        applyStimulus(1'b1, 32'h80000000, 32'h80000000, -1, 1'b0);

        // Abort paths, then a fresh divide must still work
        applyAbort(1'b0, 10);
        applyAbort(1'b1, 20);
        applyStimulus(1'b0, 32'd100, 32'd7, -1, 1'b0);

        // Operands scrambled after acceptance and start dropped mid-divide
        applyStimulus(1'b1, 32'hFFFFFC18, 32'd37, 5, 1'b1);
        applyStimulus(1'b0, 32'd999, 32'd0, 1, 1'b1);

        // Random mix; unsigned divisors stay below 2^31
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          drop;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (!s) b[31] = 1'b0;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 300));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
            applyStimulus(s, a, b, drop, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        checkVal("queueDrained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider. It is the responder end of the execute stage's divide handshake (opdata1/opdata2/start/signed in; result/ready out).
- Sits beside the execute stage. The execute stage holds start high and stalls until ready is returned, then writes the result to HI/LO.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- None. Widths are fixed: RegBus = 32, DoubleRegBus = 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high (RstEnable = 1'b1).
- signed_div_i  in  1  1 = signed division, 0 = unsigned; sampled at start acceptance.
- opdata1_i  in  32  dividend; sampled at start acceptance.
- opdata2_i  in  32  divisor; sampled at start acceptance.
- start_i  in  1  DivStart (1) requests a divide; the requester holds it until it sees ready_o, then drops it (DivStop = 0).
- annul_i  in  1  1 cancels the operation in progress (flush or exception).
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  DivResultReady (1) when result_o is valid; registered.

Behaviour:
- Reset: state=DivFree, cnt=0, result_o=0, ready_o=DivResultNotReady. Reset wins over every other input, including mid-operation.
- State DivFree:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0:
    - Latch sign flags: neg_q = signed_div_i & (opdata1_i[31]^opdata2_i[31]); neg_r = signed_div_i & opdata1_i[31].
    - If opdata2_i==0 → DivByZero.
    - Otherwise latch |op1| and |op2| (two's-complement negate a negative operand only when signed) and go to DivOn. Initialise the 65-bit work register to {32'b0, |op1|, 1'b0} and set cnt=0.
  - Otherwise stay in DivFree.
- State DivByZero: next edge → DivEnd, with the work register cleared so the result is 64'h0.
- State DivOn:
  - annul_i=1 → DivFree, ready_o=0, result_o=0. Annul takes priority over the iteration step.
  - cnt≠32, one restoring step per cycle, then cnt+1:
    - diff = work[63:32] − divisor (33-bit).
    - If diff negative, work = work<<1.
    - Else work = {diff[31:0], work[31:0], 1'b1}.
  - cnt=32 (correction cycle):
    - quotient = work[31:0], negated if neg_q.
    - remainder = work[64:33], negated if neg_r.
    - Load result_o = {remainder, quotient}, set ready_o=1, go to DivEnd, clear cnt.
- State DivEnd:
  - Hold result_o and ready_o=1 while start_i=1.
  - When start_i=0: next edge → DivFree, ready_o=0, result_o=0.
  - annul_i is ignored in DivEnd.
- Latency:
  - Start accepted at edge E0 (DivFree→DivOn). Steps occur at E1..E32, correction at E33, so ready_o is high in the cycle after E33. That is 34 clocks from start acceptance to ready.
  - Divide by zero: ready_o is high in the cycle after the second edge.
- start_i dropping during DivOn is ignored: the divide completes, and DivEnd then lasts exactly one cycle.
- Operand inputs may change after acceptance without affecting the result.
- Back-to-back operations: a new start is accepted only in DivFree, so there is at least one DivFree cycle between results.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) wraps: quotient 0x80000000, remainder 0. No exception is raised.
- All arithmetic is modulo 2^32 per half. There is no X on any output after reset.

Test Plan:
- Unsigned 100/7 (start held until ready) → ready_o rises 34 clocks after acceptance; result_o = {32'd2, 32'd14}. One cycle after start drops, ready_o=0 and result_o=0.
- Signed −7/2 (0xFFFFFFF9 / 2) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/−2 → {0x00000001, 0xFFFFFFFD}. Unsigned 0xFFFFFFF9/2 → {1, 0x7FFFFFFC}.
- Divisor 0, both signed and unsigned → ready_o high 2 clocks after acceptance; result_o = 64'h0.
- Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}. Unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- Annul at iteration 10 → next cycle in DivFree, ready_o never asserts. Sync rst at iteration 20 → all outputs 0 after the edge. A fresh 100/7 afterwards still gives {2, 14}.
- Operands changed one cycle after acceptance, and start dropped mid-operation → result still matches the latched operands; ready_o is high for exactly one cycle.
